platform_collision: RTL and testbench

- Per-frame collision scanner. Sits directly downstream of the platform position generator and consumes its 8 platform X/Y positions plus the doodle position.
- Once per frame tick it walks the 8 platforms sequentially, one per clock, and reports the first (lowest-index) platform the falling doodle has landed on.
- It emits a one-cycle bounce pulse with the platform index and surface Y. The doodle physics stage uses these to snap the doodle and launch the jump.

---
 rtl/platform_collision_if.sv | 30 +++
 rtl/platform_collision.sv | 111 +++++++++++
 tb/tb_platform_collision.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/platform_collision_if.sv
// rtl/platform_collision_if.sv - platform/doodle inputs and bounce results of the collision scanner
interface platform_collision_if;
    logic [1:0] frame_clk_edge;
    logic [7:0] state;
    logic [7:0] platform_size;
    logic [9:0] Platform_X_in [0:7];
    logic [9:0] Platform_Y_in [0:7];
    logic [9:0] Doodle_X;
    logic [9:0] Doodle_Y;
    logic       doodle_falling;
    logic       scan_busy;
    logic       done;
    logic       bounce;
    logic [2:0] bounce_idx;
    logic [9:0] bounce_Y;

    // Producer side: position generator / game logic
    modport master (
        output frame_clk_edge, state, platform_size, Platform_X_in, Platform_Y_in,
               Doodle_X, Doodle_Y, doodle_falling,
        input  scan_busy, done, bounce, bounce_idx, bounce_Y
    );

    // Scanner side
    modport slave (
        input  frame_clk_edge, state, platform_size, Platform_X_in, Platform_Y_in,
               Doodle_X, Doodle_Y, doodle_falling,
        output scan_busy, done, bounce, bounce_idx, bounce_Y
    );
endinterface

// File: rtl/platform_collision.sv
// rtl/platform_collision.sv - per-frame sequential doodle/platform landing scanner
module platform_collision #(
    parameter int DOODLE_W   = 20,
    parameter int DOODLE_H   = 20,
    parameter int HIT_BAND   = 4,
    parameter int PLAY_STATE = 1,
    parameter int N_PLAT     = 8
) (
    input  logic Clk,
    input  logic Reset,
    platform_collision_if.slave pif
);
    typedef enum logic [1:0] {IDLE, SCAN, REPORT} fsm_t;

    fsm_t       state_q;
    logic [2:0] idx_q;

    // Frame snapshot: the scan only ever looks at these, never at live inputs
    logic [9:0] px_q [0:N_PLAT-1];
    logic [9:0] py_q [0:N_PLAT-1];
    logic [7:0] size_q;
    logic [9:0] dx_q;
    logic [9:0] dy_q;
    logic       fall_q;

    logic       scan_busy_q;
    logic       done_q;
    logic       bounce_q;
    logic [2:0] bounce_idx_q;
    logic [9:0] bounce_y_q;

    logic [10:0] feet;
    logic [10:0] cur_px;
    logic [10:0] cur_py;
    logic [10:0] dx_ext;
    logic        hit;

    // Landing test for the platform currently addressed by idx_q; all sums are 11-bit so nothing wraps
    always_comb begin
        feet   = {1'b0, dy_q} + 11'(DOODLE_H);
        cur_px = {1'b0, px_q[idx_q]};
        cur_py = {1'b0, py_q[idx_q]};
        dx_ext = {1'b0, dx_q};
        hit    = fall_q
              && (feet >= cur_py)
              && (feet <  cur_py + 11'(HIT_BAND))
              && (dx_ext + 11'(DOODLE_W) > cur_px)
              && (dx_ext < cur_px + {3'b000, size_q});
    end

    // Scanner FSM: snapshot on frame edge, walk platforms, report first hit for one cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            scan_busy_q  <= 1'b0;
            done_q       <= 1'b0;
            bounce_q     <= 1'b0;
            bounce_idx_q <= 3'd0;
            bounce_y_q   <= 10'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q   <= 1'b0;
                    bounce_q <= 1'b0;
                    if (pif.frame_clk_edge == 2'b01 && pif.state == 8'(PLAY_STATE)) begin
                        for (int i = 0; i < N_PLAT; i++) begin
                            px_q[i] <= pif.Platform_X_in[i];
                            py_q[i] <= pif.Platform_Y_in[i];
                        end
                        size_q      <= pif.platform_size;
                        dx_q        <= pif.Doodle_X;
                        dy_q        <= pif.Doodle_Y;
                        fall_q      <= pif.doodle_falling;
                        idx_q       <= 3'd0;
                        scan_busy_q <= 1'b1;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit || idx_q == 3'(N_PLAT - 1)) begin
                        // Early exit on hit keeps the lowest index; a miss on the last platform reports no bounce
                        scan_busy_q <= 1'b0;
                        done_q      <= 1'b1;
                        bounce_q    <= hit;
                        if (hit) begin
                            bounce_idx_q <= idx_q;
                            bounce_y_q   <= cur_py[9:0];
                        end
                        state_q <= REPORT;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                REPORT: begin
                    // Any frame edge arriving here is dropped on purpose
                    done_q   <= 1'b0;
                    bounce_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pif.scan_busy  = scan_busy_q;
    assign pif.done       = done_q;
    assign pif.bounce     = bounce_q;
    assign pif.bounce_idx = bounce_idx_q;
    assign pif.bounce_Y   = bounce_y_q;
endmodule

// File: tb/tb_platform_collision.sv
// tb/tb_platform_collision.sv - directed self-checking bench for platform_collision
module tb_platform_collision;
    logic Clk = 1'b0;
    logic Reset;
    int   n_pass = 0;
    int   n_total = 0;

    platform_collision_if pif ();

    platform_collision dut (
        .Clk   (Clk),
        .Reset (Reset),
        .pif   (pif.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // All platforms parked far below the doodle so none qualify unless a test moves one
    task automatic park(input logic [9:0] dx, input logic [9:0] dy, input logic fall);
        for (int i = 0; i < 8; i++) begin
            pif.Platform_X_in[i] = 10'(40 * i);
            pif.Platform_Y_in[i] = 10'd450;
        end
        pif.platform_size  = 8'd60;
        pif.Doodle_X       = dx;
        pif.Doodle_Y       = dy;
        pif.doodle_falling = fall;
        pif.state          = 8'd1;
    endtask

    // Edge in cycle 0; returns the cycle number at which done is seen (99 on timeout)
    task automatic run_scan(output int cyc);
        pif.frame_clk_edge = 2'b01;
        tick();
        pif.frame_clk_edge = 2'b00;
        cyc = 1;
        while (!pif.done && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!pif.done) cyc = 99;
    endtask

    int cyc;
    int n_done;
    int first_done;

    initial begin
        pif.frame_clk_edge = 2'b00;
        park(10'd0, 10'd0, 1'b0);
        Reset = 1'b1;
        tick(); tick();
        check("rst_busy", 32'(pif.scan_busy), 0);
        check("rst_done", 32'(pif.done), 0);
        check("rst_bounce", 32'(pif.bounce), 0);
        check("rst_idx", 32'(pif.bounce_idx), 0);
        check("rst_y", 32'(pif.bounce_Y), 0);
        Reset = 1'b0;
        tick();

        // Hit on platform 0
        park(10'd160, 10'd30, 1'b1);
        pif.Platform_X_in[0] = 10'd150; pif.Platform_Y_in[0] = 10'd50;
        pif.frame_clk_edge = 2'b01;
        tick();
        pif.frame_clk_edge = 2'b00;
        check("p0_busy_c1", 32'(pif.scan_busy), 1);
        tick();
        check("p0_done_c2", 32'(pif.done), 1);
        check("p0_bounce", 32'(pif.bounce), 1);
        check("p0_idx", 32'(pif.bounce_idx), 0);
        check("p0_y", 32'(pif.bounce_Y), 50);
        check("p0_busy_c2", 32'(pif.scan_busy), 0);
        tick();
        check("p0_done_pulse", 32'(pif.done), 0);
        tick();

        // Tolerance: feet 53 is the deepest landing row for a Y=50 platform
        park(10'd160, 10'd33, 1'b1);
        pif.Platform_X_in[0] = 10'd150; pif.Platform_Y_in[0] = 10'd50;
        run_scan(cyc);
        check("tol33_cyc", 32'(cyc), 2);
        check("tol33_bounce", 32'(pif.bounce), 1);
        tick(); tick();

        // X edges on platform 3 (130..189 span, doodle 20 wide)
        park(10'd110, 10'd210, 1'b1);
        pif.Platform_X_in[3] = 10'd130; pif.Platform_Y_in[3] = 10'd230;
        run_scan(cyc);
        check("x110_cyc", 32'(cyc), 9);
        check("x110_bounce", 32'(pif.bounce), 0);
        tick(); tick();
        pif.Doodle_X = 10'd111;
        run_scan(cyc);
        check("x111_cyc", 32'(cyc), 5);
        check("x111_bounce", 32'(pif.bounce), 1);
        check("x111_idx", 32'(pif.bounce_idx), 3);
        check("x111_y", 32'(pif.bounce_Y), 230);
        tick(); tick();
        pif.Doodle_X = 10'd190;
        run_scan(cyc);
        check("x190_cyc", 32'(cyc), 9);
        check("x190_bounce", 32'(pif.bounce), 0);
        tick(); tick();
        pif.Doodle_X = 10'd189;
        run_scan(cyc);
        check("x189_cyc", 32'(cyc), 5);
        check("x189_bounce", 32'(pif.bounce), 1);
        tick(); tick();

        // Tolerance miss: feet 54 is one past the band; previous result (3, 230) must be held
        park(10'd160, 10'd34, 1'b1);
        pif.Platform_X_in[0] = 10'd150; pif.Platform_Y_in[0] = 10'd50;
        run_scan(cyc);
        check("tol34_cyc", 32'(cyc), 9);
        check("tol34_bounce", 32'(pif.bounce), 0);
        check("tol34_idx_held", 32'(pif.bounce_idx), 3);
        check("tol34_y_held", 32'(pif.bounce_Y), 230);
        tick(); tick();

        // Priority: P2 (Y 100) and P6 (Y 98) both qualify for feet 100
        park(10'd110, 10'd80, 1'b1);
        pif.Platform_X_in[2] = 10'd100; pif.Platform_Y_in[2] = 10'd100;
        pif.Platform_X_in[6] = 10'd100; pif.Platform_Y_in[6] = 10'd98;
        run_scan(cyc);
        check("prio_cyc", 32'(cyc), 4);
        check("prio_idx", 32'(pif.bounce_idx), 2);
        check("prio_y", 32'(pif.bounce_Y), 100);
        tick(); tick();
        pif.doodle_falling = 1'b0;
        run_scan(cyc);
        check("nofall_cyc", 32'(cyc), 9);
        check("nofall_bounce", 32'(pif.bounce), 0);
        tick(); tick();

        // Second edge during a no-hit scan is dropped
        park(10'd110, 10'd80, 1'b0);
        pif.frame_clk_edge = 2'b01;
        tick();
        n_done = 0;
        first_done = 0;
        for (int c = 1; c <= 15; c++) begin
            if (pif.done) begin
                n_done++;
                if (first_done == 0) first_done = c;
            end
            pif.frame_clk_edge = (c == 3) ? 2'b01 : 2'b00;
            tick();
        end
        check("busy_edge_ndone", 32'(n_done), 1);
        check("busy_edge_cyc", 32'(first_done), 9);
        check("busy_edge_idle", 32'(pif.scan_busy), 0);

        // Snapshot: moving P3 mid-scan has no effect
        park(10'd111, 10'd210, 1'b1);
        pif.Platform_X_in[3] = 10'd130; pif.Platform_Y_in[3] = 10'd230;
        pif.frame_clk_edge = 2'b01;
        tick();
        pif.frame_clk_edge = 2'b00;
        tick();
        pif.Platform_Y_in[3] = 10'd300;
        pif.Doodle_X = 10'd0;
        cyc = 2;
        while (!pif.done && cyc < 20) begin
            tick();
            cyc++;
        end
        check("snap_cyc", 32'(cyc), 5);
        check("snap_y", 32'(pif.bounce_Y), 230);
        tick(); tick();

        // Reset at cycle 4 of a no-hit scan
        park(10'd110, 10'd80, 1'b0);
        pif.frame_clk_edge = 2'b01;
        tick();
        pif.frame_clk_edge = 2'b00;
        tick(); tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rstmid_busy", 32'(pif.scan_busy), 0);
        check("rstmid_idx", 32'(pif.bounce_idx), 0);
        check("rstmid_y", 32'(pif.bounce_Y), 0);
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (pif.done || pif.scan_busy) n_done++;
            tick();
        end
        check("rstmid_quiet", 32'(n_done), 0);

        // Edge outside PLAY_STATE does not start a scan
        park(10'd160, 10'd30, 1'b1);
        pif.Platform_X_in[0] = 10'd150; pif.Platform_Y_in[0] = 10'd50;
        pif.state = 8'd2;
        pif.frame_clk_edge = 2'b01;
        tick();
        pif.frame_clk_edge = 2'b00;
        check("gate_busy", 32'(pif.scan_busy), 0);
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (pif.done || pif.scan_busy) n_done++;
            tick();
        end
        check("gate_quiet", 32'(n_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
